// File: rtl/rs_issue_if.sv
// Dispatch, completion-broadcast and issue-slot signals of the reservation station.
// The master side is the pipeline environment; the slave side is rs_issue.
interface rs_issue_if #(
    parameter int unsigned PREG_W = 7,
    parameter int unsigned ROB_W  = 6,
    parameter int unsigned NUM_FU = 3,
    parameter int unsigned CNT_W  = 6
);
    logic                     alloc_valid;
    logic                     alloc_ready;
    logic [PREG_W-1:0]        alloc_rd;
    logic [PREG_W-1:0]        alloc_rs1;
    logic                     alloc_rs1_rdy;
    logic [PREG_W-1:0]        alloc_rs2;
    logic                     alloc_rs2_rdy;
    logic [1:0]               alloc_fu;
    logic [ROB_W-1:0]         alloc_rob;
    logic [NUM_FU-1:0]        cdb_valid;
    logic [NUM_FU*PREG_W-1:0] cdb_tag;
    logic [NUM_FU-1:0]        iss_valid;
    logic [NUM_FU-1:0]        iss_ready;
    logic [NUM_FU*PREG_W-1:0] iss_rd;
    logic [NUM_FU*PREG_W-1:0] iss_rs1;
    logic [NUM_FU*PREG_W-1:0] iss_rs2;
    logic [NUM_FU*ROB_W-1:0]  iss_rob;
    logic [CNT_W-1:0]         free_count;
    logic                     err_illegal_fu;

    modport master (
        output alloc_valid, alloc_rd, alloc_rs1, alloc_rs1_rdy, alloc_rs2, alloc_rs2_rdy,
               alloc_fu, alloc_rob, cdb_valid, cdb_tag, iss_ready,
        input  alloc_ready, iss_valid, iss_rd, iss_rs1, iss_rs2, iss_rob, free_count,
               err_illegal_fu
    );

    modport slave (
        input  alloc_valid, alloc_rd, alloc_rs1, alloc_rs1_rdy, alloc_rs2, alloc_rs2_rdy,
               alloc_fu, alloc_rob, cdb_valid, cdb_tag, iss_ready,
        output alloc_ready, iss_valid, iss_rd, iss_rs1, iss_rs2, iss_rob, free_count,
               err_illegal_fu
    );
endinterface

// File: rtl/rs_issue.sv
// Reservation-station entry pool with CDB wakeup and one registered issue slot per FU.
// Each slot picks the lowest-index entry of its FU whose sources are both ready.
module rs_issue #(
    parameter int unsigned RS_DEPTH = 32,
    parameter int unsigned PREG_W   = 7,
    parameter int unsigned ROB_W    = 6,
    parameter int unsigned NUM_FU   = 3,
    parameter int unsigned CNT_W    = $clog2(RS_DEPTH + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    rs_issue_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0]      inuse_q, rs1_rdy_q, rs2_rdy_q;
    logic [PREG_W-1:0]        rd_q  [RS_DEPTH];
    logic [PREG_W-1:0]        rs1_q [RS_DEPTH];
    logic [PREG_W-1:0]        rs2_q [RS_DEPTH];
    logic [1:0]               fu_q  [RS_DEPTH];
    logic [ROB_W-1:0]         rob_q [RS_DEPTH];

    logic [NUM_FU-1:0]        iss_valid_q;
    logic [NUM_FU*PREG_W-1:0] iss_rd_q, iss_rs1_q, iss_rs2_q;
    logic [NUM_FU*ROB_W-1:0]  iss_rob_q;
    logic [CNT_W-1:0]         free_count_q, free_count_d;
    logic                     err_q;

    logic                     alloc_fire, alloc_legal, alloc_wr;
    logic [IDX_W-1:0]         alloc_idx;
    logic [NUM_FU-1:0]        sel_found, load;
    logic [IDX_W-1:0]         sel_idx [NUM_FU];
    logic [RS_DEPTH-1:0]      issued;
    logic [CNT_W-1:0]         load_cnt;

    function automatic logic cdb_hit(input logic [PREG_W-1:0]        tag,
                                     input logic [NUM_FU-1:0]        vld,
                                     input logic [NUM_FU*PREG_W-1:0] tags);
        cdb_hit = 1'b0;
        for (int f = 0; f < int'(NUM_FU); f++) begin
            if (vld[f] && tags[f*PREG_W +: PREG_W] == tag) cdb_hit = 1'b1;
        end
    endfunction

    assign bus.alloc_ready = (free_count_q != '0);
    assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
    assign alloc_legal     = 32'(bus.alloc_fu) < NUM_FU;
    assign alloc_wr        = alloc_fire && alloc_legal;

    always_comb begin
        alloc_idx = '0;
        for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
            if (!inuse_q[i]) alloc_idx = IDX_W'(i);
        end
    end

    // Selection uses registered ready bits only; same-cycle broadcasts count next cycle.
    always_comb begin
        issued   = '0;
        load_cnt = '0;
        for (int f = 0; f < int'(NUM_FU); f++) begin
            sel_found[f] = 1'b0;
            sel_idx[f]   = '0;
            for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
                if (inuse_q[i] && fu_q[i] == 2'(f) && rs1_rdy_q[i] && rs2_rdy_q[i]) begin
                    sel_found[f] = 1'b1;
                    sel_idx[f]   = IDX_W'(i);
                end
            end
            load[f] = sel_found[f] && (!iss_valid_q[f] || bus.iss_ready[f]);
            if (load[f]) begin
                issued[sel_idx[f]] = 1'b1;
                load_cnt           = load_cnt + CNT_W'(1);
            end
        end
    end

    assign free_count_d = free_count_q - CNT_W'(alloc_wr) + load_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inuse_q      <= '0;
            rs1_rdy_q    <= '0;
            rs2_rdy_q    <= '0;
            for (int i = 0; i < int'(RS_DEPTH); i++) begin
                rd_q[i]  <= '0;
                rs1_q[i] <= '0;
                rs2_q[i] <= '0;
                fu_q[i]  <= '0;
                rob_q[i] <= '0;
            end
            iss_valid_q  <= '0;
            iss_rd_q     <= '0;
            iss_rs1_q    <= '0;
            iss_rs2_q    <= '0;
            iss_rob_q    <= '0;
            free_count_q <= CNT_W'(RS_DEPTH);
            err_q        <= 1'b0;
        end else if (flush) begin
            inuse_q      <= '0;
            iss_valid_q  <= '0;
            free_count_q <= CNT_W'(RS_DEPTH);
            err_q        <= 1'b0;
        end else begin
            err_q        <= alloc_fire && !alloc_legal;
            free_count_q <= free_count_d;
            for (int i = 0; i < int'(RS_DEPTH); i++) begin
                if (inuse_q[i]) begin
                    if (cdb_hit(rs1_q[i], bus.cdb_valid, bus.cdb_tag)) rs1_rdy_q[i] <= 1'b1;
                    if (cdb_hit(rs2_q[i], bus.cdb_valid, bus.cdb_tag)) rs2_rdy_q[i] <= 1'b1;
                end
                if (issued[i]) inuse_q[i] <= 1'b0;
            end
            // The allocated slot was free at cycle start, so it never collides with an issue.
            if (alloc_wr) begin
                inuse_q[alloc_idx]   <= 1'b1;
                rd_q[alloc_idx]      <= bus.alloc_rd;
                rs1_q[alloc_idx]     <= bus.alloc_rs1;
                rs2_q[alloc_idx]     <= bus.alloc_rs2;
                fu_q[alloc_idx]      <= bus.alloc_fu;
                rob_q[alloc_idx]     <= bus.alloc_rob;
                rs1_rdy_q[alloc_idx] <= bus.alloc_rs1_rdy |
                                        cdb_hit(bus.alloc_rs1, bus.cdb_valid, bus.cdb_tag);
                rs2_rdy_q[alloc_idx] <= bus.alloc_rs2_rdy |
                                        cdb_hit(bus.alloc_rs2, bus.cdb_valid, bus.cdb_tag);
            end
            for (int f = 0; f < int'(NUM_FU); f++) begin
                if (load[f]) begin
                    iss_valid_q[f]                 <= 1'b1;
                    iss_rd_q[f*PREG_W +: PREG_W]   <= rd_q[sel_idx[f]];
                    iss_rs1_q[f*PREG_W +: PREG_W]  <= rs1_q[sel_idx[f]];
                    iss_rs2_q[f*PREG_W +: PREG_W]  <= rs2_q[sel_idx[f]];
                    iss_rob_q[f*ROB_W +: ROB_W]    <= rob_q[sel_idx[f]];
                end else if (bus.iss_ready[f]) begin
                    iss_valid_q[f] <= 1'b0;
                end
            end
        end
    end

    assign bus.iss_valid      = iss_valid_q;
    assign bus.iss_rd         = iss_rd_q;
    assign bus.iss_rs1        = iss_rs1_q;
    assign bus.iss_rs2        = iss_rs2_q;
    assign bus.iss_rob        = iss_rob_q;
    assign bus.free_count     = free_count_q;
    assign bus.err_illegal_fu = err_q;
endmodule
